// File: rtl/rattlesnake_instruction_fetch_if.sv
// Instruction memory read bus between the fetch stage (master) and instruction memory (slave).
//   mem_read_en   : one-cycle read strobe (master -> slave)
//   mem_word_addr : word address of the read (master -> slave)
//   mem_read_ack  : read data valid, at least one cycle after the strobe (slave -> master)
//   mem_data      : instruction word, valid with mem_read_ack (slave -> master)
`ifndef XLEN
`define XLEN 32
`endif

interface rattlesnake_instruction_fetch_if #(
  parameter int unsigned MEM_ADDR_BITS = 30
);
  logic                     mem_read_en;
  logic [MEM_ADDR_BITS-1:0] mem_word_addr;
  logic                     mem_read_ack;
  logic [`XLEN-1:0]         mem_data;

  modport master (
    output mem_read_en,
    output mem_word_addr,
    input  mem_read_ack,
    input  mem_data
  );

  modport slave (
    input  mem_read_en,
    input  mem_word_addr,
    output mem_read_ack,
    output mem_data
  );
endinterface

// File: rtl/rattlesnake_instruction_fetch.sv
// Non-pipelined instruction fetch stage: one memory read outstanding at a time.
// Fetches the word at PC on each fetch_enable pulse and hands it to decode with a one-cycle
// enable_out pulse. Jumps redirect the PC; a word already in flight when a jump lands is
// dropped and refetched from the new PC.
//
// Ports:
//   clk, reset_n (async, active low), sync_reset (sync, active high)
//   fetch_init / start_addr      : restart from start_addr, abandon any fetch
//   fetch_enable                 : fetch the instruction at PC
//   jump_active / jump_addr      : redirect PC
//   mem_bus                      : instruction memory read bus (master side)
//   enable_out, IR_out, IR_original_out, PC_out : fetched instruction to decode
//   busy                         : a memory read is outstanding
//   exception_instr_addr_misaligned : misaligned fetch trap pulse
//
// Build option: define RATTLESNAKE_FETCH_MISALIGN_TRAP_EN to trap misaligned fetches.
// When undefined, every PC load is forced to word alignment and the trap output is tied 0.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_BITWIDTH
`define PC_BITWIDTH 32
`endif

module rattlesnake_instruction_fetch #(
  parameter logic [`PC_BITWIDTH-1:0] START_ADDR    = 32'h0000_0000,
  parameter int unsigned             MEM_ADDR_BITS = 30
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic                     fetch_init,
  input  logic [`PC_BITWIDTH-1:0]  start_addr,
  input  logic                     fetch_enable,
  input  logic                     jump_active,
  input  logic [`PC_BITWIDTH-1:0]  jump_addr,
  rattlesnake_instruction_fetch_if.master mem_bus,
  output logic                     enable_out,
  output logic [`XLEN-1:0]         IR_out,
  output logic [`XLEN-1:0]         IR_original_out,
  output logic [`PC_BITWIDTH-1:0]  PC_out,
  output logic                     busy,
  output logic                     exception_instr_addr_misaligned
);

  localparam logic [`PC_BITWIDTH-1:0] PcMask = {{(`PC_BITWIDTH-2){1'b1}}, 2'b00};

`ifdef RATTLESNAKE_FETCH_MISALIGN_TRAP_EN
  localparam logic [`PC_BITWIDTH-1:0] StartPc = START_ADDR;
`else
  localparam logic [`PC_BITWIDTH-1:0] StartPc = START_ADDR & PcMask;
`endif

  function automatic logic [`PC_BITWIDTH-1:0] load_pc(input logic [`PC_BITWIDTH-1:0] a);
`ifdef RATTLESNAKE_FETCH_MISALIGN_TRAP_EN
    return a;
`else
    return a & PcMask;
`endif
  endfunction

  typedef enum logic {StIdle, StWaitAck} state_e;

  state_e                   state_q;
  logic [`PC_BITWIDTH-1:0]  pc_q;
  logic                     drop_q;     // in-flight word belongs to a stale PC
  logic                     refetch_q;  // reissue the read at the updated PC this cycle
  logic                     enable_q;
  logic [`XLEN-1:0]         ir_q;
  logic [`PC_BITWIDTH-1:0]  pc_out_q;

  logic [`PC_BITWIDTH-1:0]  jump_pc;
  logic [`PC_BITWIDTH-1:0]  target_pc;
  logic                     addr_misaligned;
  logic                     issue_new;

  // A jump in the same cycle as a read is forwarded so the read already targets the new PC.
  assign jump_pc         = load_pc(jump_addr);
  assign target_pc       = jump_active ? jump_pc : pc_q;
  // Only reachable with the trap build; otherwise all PC loads are aligned.
  assign addr_misaligned = |target_pc[1:0];
  assign issue_new       = (state_q == StIdle) && fetch_enable;

  assign mem_bus.mem_read_en   = reset_n && !sync_reset && !fetch_init &&
                                 ((issue_new && !addr_misaligned) || refetch_q);
  assign mem_bus.mem_word_addr = target_pc[MEM_ADDR_BITS+1:2];

  assign enable_out      = enable_q;
  assign IR_out          = ir_q;
  assign IR_original_out = ir_q;
  assign PC_out          = pc_out_q;
  assign busy            = (state_q == StWaitAck);

`ifdef RATTLESNAKE_FETCH_MISALIGN_TRAP_EN
  logic exc_q;
  assign exception_instr_addr_misaligned = exc_q;
`else
  assign exception_instr_addr_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pc_q      <= StartPc;
      drop_q    <= 1'b0;
      refetch_q <= 1'b0;
      enable_q  <= 1'b0;
      ir_q      <= '0;
      pc_out_q  <= '0;
`ifdef RATTLESNAKE_FETCH_MISALIGN_TRAP_EN
      exc_q     <= 1'b0;
`endif
    end else if (sync_reset) begin
      state_q   <= StIdle;
      pc_q      <= StartPc;
      drop_q    <= 1'b0;
      refetch_q <= 1'b0;
      enable_q  <= 1'b0;
      ir_q      <= '0;
      pc_out_q  <= '0;
`ifdef RATTLESNAKE_FETCH_MISALIGN_TRAP_EN
      exc_q     <= 1'b0;
`endif
    end else begin
      enable_q  <= 1'b0;
      refetch_q <= 1'b0;
`ifdef RATTLESNAKE_FETCH_MISALIGN_TRAP_EN
      exc_q     <= 1'b0;
`endif
      if (fetch_init) begin
        // Abandon everything; a late ack will arrive in StIdle and be ignored.
        state_q <= StIdle;
        pc_q    <= load_pc(start_addr);
        drop_q  <= 1'b0;
      end else begin
        if (jump_active) pc_q <= jump_pc;
        unique case (state_q)
          StIdle: begin
            if (fetch_enable) begin
`ifdef RATTLESNAKE_FETCH_MISALIGN_TRAP_EN
              if (addr_misaligned) begin
                exc_q    <= 1'b1;
                pc_out_q <= target_pc;
              end else begin
                state_q <= StWaitAck;
              end
`else
              state_q <= StWaitAck;
`endif
            end
          end
          StWaitAck: begin
            if (mem_bus.mem_read_ack) begin
              if (drop_q || jump_active) begin
                // Stale word: discard and reread from the (possibly just updated) PC.
                drop_q    <= 1'b0;
                refetch_q <= 1'b1;
              end else begin
                ir_q     <= mem_bus.mem_data;
                pc_out_q <= pc_q;
                enable_q <= 1'b1;
                pc_q     <= pc_q + `PC_BITWIDTH'(4);
                state_q  <= StIdle;
              end
            end else if (jump_active && !refetch_q) begin
              // A reissue in this cycle already used the forwarded jump target.
              drop_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rattlesnake_instruction_fetch.sv
// Directed bench for the instruction fetch stage. A memory responder returns
// instr_of(word) after a programmable latency; the scoreboard holds the expected read
// addresses, delivered PCs and trap PCs, and busy is predicted from the order of
// observed requests and completions.
module tb_rattlesnake_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_reset = 1'b0;
  logic        fetch_init = 1'b0;
  logic [31:0] start_addr = '0;
  logic        fetch_enable = 1'b0;
  logic        jump_active = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        enable_out;
  logic [31:0] IR_out;
  logic [31:0] IR_original_out;
  logic [31:0] PC_out;
  logic        busy;
  logic        exc;

  rattlesnake_instruction_fetch_if #(.MEM_ADDR_BITS(30)) mem_if ();

  rattlesnake_instruction_fetch #(
    .START_ADDR   (32'h0000_0000),
    .MEM_ADDR_BITS(30)
  ) dut (
    .clk                            (clk),
    .reset_n                        (reset_n),
    .sync_reset                     (sync_reset),
    .fetch_init                     (fetch_init),
    .start_addr                     (start_addr),
    .fetch_enable                   (fetch_enable),
    .jump_active                    (jump_active),
    .jump_addr                      (jump_addr),
    .mem_bus                        (mem_if),
    .enable_out                     (enable_out),
    .IR_out                         (IR_out),
    .IR_original_out                (IR_original_out),
    .PC_out                         (PC_out),
    .busy                           (busy),
    .exception_instr_addr_misaligned(exc)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [29:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_exc[$];
  bit          chk_en = 1'b0;
  int          mem_lat = 1;

  function automatic logic [31:0] instr_of(input logic [29:0] word);
    return {word[23:0], 8'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got unexpected event with value %h", name, act);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_enable(input int budget);
    int n = 0;
    while (!enable_out && n < budget) begin
      cyc();
      n++;
    end
    if (!enable_out) fail_event("enable_timeout", 32'(budget));
  endtask

  // Memory responder: captures a request at the negedge, acks mem_lat cycles later.
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [29:0] paddr = '0;
  initial begin
    mem_if.mem_read_ack = 1'b0;
    mem_if.mem_data     = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_if.mem_read_ack = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_if.mem_read_ack = 1'b1;
          mem_if.mem_data     = instr_of(paddr);
          pend                = 1'b0;
        end
      end
      @(negedge clk);
      if (mem_if.mem_read_en) begin
        pend  = 1'b1;
        cnt   = mem_lat;
        paddr = mem_if.mem_word_addr;
      end
    end
  end

  // Scoreboard compare, every cycle at the negedge.
  int last_req = 0;
  int last_done = 0;
  int seq = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_if.mem_read_en) begin
        if (exp_req.size() == 0) fail_event("unexpected_read", 32'(mem_if.mem_word_addr));
        else check("read_addr", 32'(mem_if.mem_word_addr), 32'(exp_req.pop_front()));
      end
      if (enable_out) begin
        if (exp_pc.size() == 0) fail_event("unexpected_enable", PC_out);
        else begin
          logic [31:0] p;
          p = exp_pc.pop_front();
          check("pc_out", PC_out, p);
          check("ir_out", IR_out, instr_of(p[31:2]));
          check("ir_original_out", IR_original_out, instr_of(p[31:2]));
        end
        last_done = ++seq;
      end
      if (exc) begin
        if (exp_exc.size() == 0) fail_event("unexpected_exception", PC_out);
        else check("exc_pc_out", PC_out, exp_exc.pop_front());
      end
      check("busy", 32'(busy), 32'(last_req > last_done));
      if (mem_if.mem_read_en) last_req = ++seq;
      if (fetch_init || sync_reset) last_done = ++seq;
    end
  end

  initial begin
    // Reset.
    fetch_enable = 1'b1;
    cyc();
    cyc();
    check("rst_read_en", 32'(mem_if.mem_read_en), 32'h0);
    fetch_enable = 1'b0;
    reset_n = 1'b1;
    cyc();
    check("rst_ir_out", IR_out, 32'h0);
    check("rst_ir_original", IR_original_out, 32'h0);
    check("rst_pc_out", PC_out, 32'h0);
    check("rst_enable", 32'(enable_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_exc", 32'(exc), 32'h0);
    chk_en = 1'b1;

    // Single fetch, 1-cycle memory, then the next fetch at PC 4.
    mem_lat = 1;
    exp_req.push_back(30'h0);
    exp_pc.push_back(32'h0);
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
    check("lat_no_enable_yet", 32'(enable_out), 32'h0);
    cyc();
    check("t1_enable", 32'(enable_out), 32'h1);
    check("t1_ir", IR_out, 32'h0000_0013);
    check("t1_pc", PC_out, 32'h0);
    exp_req.push_back(30'h1);
    exp_pc.push_back(32'h4);
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
    wait_enable(10);
    cyc();

    // Synchronous reset, then three back-to-back fetches with 3-cycle memory.
    sync_reset = 1'b1;
    cyc();
    sync_reset = 1'b0;
    mem_lat = 3;
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(30'(i));
      exp_pc.push_back(32'(4 * i));
      fetch_enable = 1'b1;
      cyc();
      fetch_enable = 1'b0;
      wait_enable(10);
    end
    cyc();

    // Jump while waiting: first word dropped, reread at 0x100.
    mem_lat = 2;
    exp_req.push_back(30'h3);
    exp_req.push_back(30'h40);
    exp_pc.push_back(32'h100);
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
    jump_active  = 1'b1;
    jump_addr    = 32'h100;
    cyc();
    jump_active = 1'b0;
    wait_enable(12);
    check("t3_pc", PC_out, 32'h100);
    cyc();

    // Jump in the same cycle as the ack.
    exp_req.push_back(30'h41);
    exp_req.push_back(30'h80);
    exp_pc.push_back(32'h200);
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
    cyc();
    jump_active = 1'b1;
    jump_addr   = 32'h200;
    cyc();
    jump_active = 1'b0;
    wait_enable(12);
    cyc();

    // fetch_init mid-wait: the late ack is ignored.
    mem_lat = 3;
    exp_req.push_back(30'h81);
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
    fetch_init   = 1'b1;
    start_addr   = 32'h8000_0000;
    cyc();
    fetch_init = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("t5_idle_busy", 32'(busy), 32'h0);
    mem_lat = 1;
    exp_req.push_back(30'h2000_0000);
    exp_pc.push_back(32'h8000_0000);
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
    wait_enable(10);
    check("t5_pc", PC_out, 32'h8000_0000);
    cyc();

    // Jump to a misaligned address, then fetch.
    jump_active = 1'b1;
    jump_addr   = 32'h102;
    cyc();
    jump_active = 1'b0;
`ifdef RATTLESNAKE_FETCH_MISALIGN_TRAP_EN
    exp_exc.push_back(32'h102);
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
    check("t6_exc", 32'(exc), 32'h1);
    check("t6_no_enable", 32'(enable_out), 32'h0);
    cyc();
`else
    exp_req.push_back(30'h40);
    exp_pc.push_back(32'h100);
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
    check("t6_no_exc", 32'(exc), 32'h0);
    wait_enable(10);
    check("t6_pc", PC_out, 32'h100);
    cyc();
`endif

    // Jump and fetch together, at the top of the address space; PC wraps to 0.
    exp_req.push_back(30'h3FFF_FFFF);
    exp_pc.push_back(32'hFFFF_FFFC);
    jump_active  = 1'b1;
    jump_addr    = 32'hFFFF_FFFC;
    fetch_enable = 1'b1;
    cyc();
    jump_active  = 1'b0;
    fetch_enable = 1'b0;
    wait_enable(10);
    exp_req.push_back(30'h0);
    exp_pc.push_back(32'h0);
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
    wait_enable(10);
    check("t7_pc_wrap", PC_out, 32'h0);

    for (int i = 0; i < 4; i++) cyc();
    check("left_reads", 32'(exp_req.size()), 32'h0);
    check("left_enables", 32'(exp_pc.size()), 32'h0);
    check("left_exceptions", 32'(exp_exc.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rattlesnake_instruction_fetch.md
Name: rattlesnake_instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decode stage.
- On each controller fetch request, reads one 32-bit instruction word from instruction memory at the current PC.
- Presents the word to decode as enable_out/IR_out/IR_original_out/PC_out.
- Tracks PC sequencing, jump/branch redirects and in-flight request cancellation. Non-pipelined: one instruction outstanding at a time.

Parameters:
- START_ADDR, 32'h0000_0000, PC value loaded at reset, sync_reset and fetch_init.
- MEM_ADDR_BITS, 30, word address width driven to instruction memory.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sync_reset  input  1  synchronous reset, same effect as reset_n.
- fetch_init  input  1  pulse: load PC from start_addr, abort any fetch.
- start_addr  input  `PC_BITWIDTH  boot/restart address used with fetch_init.
- fetch_enable  input  1  pulse from controller: fetch the instruction at PC.
- jump_active  input  1  pulse: redirect PC to jump_addr (branch/JAL/JALR/trap/MRET).
- jump_addr  input  `PC_BITWIDTH  redirect target.
- mem_read_en  output  1  one-cycle read strobe to instruction memory.
- mem_word_addr  output  MEM_ADDR_BITS  word address, equal to PC[MEM_ADDR_BITS+1:2].
- mem_read_ack  input  1  read data valid; arrives at least 1 cycle after mem_read_en.
- mem_data  input  `XLEN  instruction word, valid with mem_read_ack.
- enable_out  output  1  one-cycle pulse: IR/PC outputs hold a new instruction.
- IR_out  output  `XLEN  instruction word to decode.
- IR_original_out  output  `XLEN  raw fetched word; equal to IR_out in this block.
- PC_out  output  `PC_BITWIDTH  address of IR_out.
- busy  output  1  high while a request is outstanding.
- exception_instr_addr_misaligned  output  1  see Optional Feature.

Behaviour:
- Reset (reset_n low, or sync_reset high at an edge):
  - PC = START_ADDR; state IDLE.
  - mem_read_en, enable_out, busy, exception output = 0.
  - IR_out, IR_original_out, PC_out = 0; drop flag = 0.
- State IDLE:
  - fetch_enable: mem_read_en = 1 for exactly one cycle with mem_word_addr from PC; next state WAIT_ACK; busy = 1.
  - Otherwise remain in IDLE.
- State WAIT_ACK:
  - mem_read_ack with drop = 0: latch IR_out = IR_original_out = mem_data and PC_out = PC.
  - enable_out pulses the following cycle; PC += 4; return to IDLE; busy = 0.
  - Latency from fetch_enable to enable_out is memory latency + 1 cycle (minimum 2).
- Redirect (jump_active):
  - PC = jump_addr on the next edge, in any state.
  - In WAIT_ACK without a same-cycle ack: set drop = 1.
  - Ack while drop = 1: discard data, clear drop, issue a new mem_read_en at the updated PC on the next cycle, stay in WAIT_ACK. No enable_out for the dropped word.
  - jump_active in the same cycle as mem_read_ack: the returned word is discarded, and a refetch from jump_addr is issued.
  - jump_active and fetch_enable in the same cycle in IDLE: the request uses jump_addr. jump_addr is forwarded combinationally to mem_word_addr.
- fetch_init:
  - Highest priority after reset: PC = start_addr; state IDLE; drop = 0.
  - No enable_out, even if an ack arrives in the same cycle.
  - Acks later arriving while in IDLE are ignored.
- fetch_enable while busy is ignored. The controller must not issue it.
- PC arithmetic is modulo 2^`PC_BITWIDTH; 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
- Macro: RATTLESNAKE_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A fetch with PC[1:0] != 0 issues no mem_read_en.
  - exception_instr_addr_misaligned pulses 1 cycle after fetch_enable, PC_out = faulting PC, enable_out stays 0, state stays IDLE.
- Undefined:
  - PC[1:0] is forced to 2'b00 on every load (reset, init, jump).
  - exception_instr_addr_misaligned is tied 0.

Test Plan:
- Reset, fetch_enable, memory ack after 1 cycle with 32'h0000_0013 -> mem_read_en at word 0; enable_out 1 cycle later; IR_out = 32'h13; PC_out = 0; next fetch at PC 4.
- Three back-to-back fetches with 3-cycle memory latency -> PC_out 0, 4, 8; exactly one enable_out pulse each; busy high only during waits.
- jump_active to 32'h100 while in WAIT_ACK, ack 2 cycles later -> first word dropped, no enable_out; re-request at word 32'h40; PC_out = 32'h100.
- jump_active in the same cycle as ack -> data discarded; refetch at jump_addr.
- fetch_init with start_addr 32'h8000_0000 mid-wait -> pending ack ignored; next fetch PC_out = 32'h8000_0000.
- Feature on: jump to 32'h102 then fetch_enable -> exception pulse, PC_out = 32'h102, no mem_read_en. Feature off: same stimulus -> fetch at 32'h100.
